// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus bundle: instruction fields and memory/branch/trap status
// flow into the control unit; datapath strobes, mux selects, retire pulse,
// sticky fault flags and the FSM state flow out to the datapath.
//   master : the control unit (drives strobes, samples status)
//   slave  : the datapath/memory side (drives status, samples strobes)
interface multicycle_control_unit_if;
    logic [6:0] opcode;        // IR[6:0]
    logic [2:0] funct3;        // IR[14:12]
    logic       mem_ready;     // memory completes current request this cycle
    logic       branch_taken;  // ALU compare result
    logic       trap_ack;      // external handler acknowledges the trap
    logic       pc_write;      // PC load strobe
    logic [1:0] pc_src;        // 00 PC+4, 01 branch/JAL target, 10 JALR target
    logic       ir_write;      // IR load strobe
    logic       mem_req;       // memory request
    logic       mem_we;        // 1 = store
    logic [1:0] mem_size;      // access size
    logic [1:0] alu_op;        // 00 add, 01 compare, 10 funct-decoded
    logic       alu_src_a;     // 0 rs1, 1 PC
    logic [1:0] alu_src_b;     // 00 rs2, 01 imm, 10 constant 4
    logic       reg_write;     // register file write strobe
    logic [1:0] wb_sel;        // 00 ALU, 01 memory data, 10 PC
    logic       instr_done;    // pulse on final cycle of a retired instruction
    logic       illegal;       // sticky illegal-opcode flag
    logic       mem_fault;     // sticky memory-timeout flag
    logic [2:0] state;         // FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5

    modport master (
        input  opcode, funct3, mem_ready, branch_taken, trap_ack,
        output pc_write, pc_src, ir_write, mem_req, mem_we, mem_size,
               alu_op, alu_src_a, alu_src_b, reg_write, wb_sel,
               instr_done, illegal, mem_fault, state
    );

    modport slave (
        output opcode, funct3, mem_ready, branch_taken, trap_ack,
        input  pc_write, pc_src, ir_write, mem_req, mem_we, mem_size,
               alu_op, alu_src_a, alu_src_b, reg_write, wb_sel,
               instr_done, illegal, mem_fault, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB per
// instruction, stalls on the memory ready handshake, and traps on illegal
// opcodes or a memory wait that exceeds MEM_TIMEOUT cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : control bundle (master side), see multicycle_control_unit_if
// Parameters:
//   MEM_TIMEOUT : max wait cycles in FETCH/MEM before a fault, 0 disables
//   TMO_W       : wait counter width, 2**TMO_W > MEM_TIMEOUT
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam bit               TMO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_q;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic             illegal_q;
    logic             fault_q;
    logic             opcode_legal;
    logic             timeout_hit;
    logic             waiting;

    // funct3[2] selects signed/unsigned loads; that is handled in the datapath.
    logic             unused_funct3_msb;
    assign unused_funct3_msb = funct3_q[2];

    always_comb begin
        opcode_legal = 1'b0;
        case (bus.opcode)
            OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default:                           opcode_legal = 1'b0;
        endcase
    end

    assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM);
    // A ready arriving in the same cycle as the limit wins over the fault.
    assign timeout_hit = TMO_EN && waiting && (wait_q == TMO_LIMIT) && !bus.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            // Any state change clears the counter, so it starts at 0 on
            // every entry to FETCH or MEM; staying there means still waiting.
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (waiting && !bus.mem_ready) begin
                wait_q <= wait_q + TMO_W'(1);
            end

            if (state_q == S_DECODE) begin
                opcode_q <= bus.opcode;
                funct3_q <= bus.funct3;
                if (!opcode_legal) begin
                    illegal_q <= 1'b1;
                end
            end

            if (timeout_hit) begin
                fault_q <= 1'b1;
            end

            if ((state_q == S_TRAP) && bus.trap_ack) begin
                illegal_q <= 1'b0;
                fault_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.ir_write   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_size   = 2'b00;
        bus.alu_op     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.reg_write  = 1'b0;
        bus.wb_sel     = 2'b00;
        bus.instr_done = 1'b0;

        // Outputs are gated by rst so no strobe leaks out while the async
        // reset holds the FSM in FETCH.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_size  = 2'b10;
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'b00;
                        state_d      = S_DECODE;
                    end else if (timeout_hit) begin
                        state_d = S_TRAP;
                    end
                end

                S_DECODE: begin
                    state_d = opcode_legal ? S_EXEC : S_TRAP;
                end

                S_EXEC: begin
                    case (opcode_q)
                        OP_LOAD, OP_STORE: begin
                            bus.alu_src_b = 2'b01;
                            state_d       = S_MEM;
                        end
                        OP_OP: begin
                            bus.alu_op = 2'b10;
                            state_d    = S_WB;
                        end
                        OP_OPIMM: begin
                            bus.alu_op    = 2'b10;
                            bus.alu_src_b = 2'b01;
                            state_d       = S_WB;
                        end
                        OP_LUI: begin
                            bus.alu_src_b = 2'b01;
                            state_d       = S_WB;
                        end
                        OP_AUIPC: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_src_b = 2'b01;
                            state_d       = S_WB;
                        end
                        OP_BRANCH: begin
                            bus.alu_op     = 2'b01;
                            bus.pc_write   = bus.branch_taken;
                            bus.pc_src     = 2'b01;
                            bus.instr_done = 1'b1;
                            state_d        = S_FETCH;
                        end
                        OP_JAL, OP_JALR: begin
                            // Link value is the already-incremented PC; the
                            // register file samples it before the PC update.
                            bus.alu_src_a  = (opcode_q == OP_JAL);
                            bus.alu_src_b  = 2'b01;
                            bus.pc_write   = 1'b1;
                            bus.pc_src     = (opcode_q == OP_JAL) ? 2'b01 : 2'b10;
                            bus.reg_write  = 1'b1;
                            bus.wb_sel     = 2'b10;
                            bus.instr_done = 1'b1;
                            state_d        = S_FETCH;
                        end
                        default: begin
                            state_d = S_FETCH;
                        end
                    endcase
                end

                S_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = (opcode_q == OP_STORE);
                    bus.mem_size = funct3_q[1:0];
                    if (bus.mem_ready) begin
                        if (opcode_q == OP_STORE) begin
                            bus.instr_done = 1'b1;
                            state_d        = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (timeout_hit) begin
                        state_d = S_TRAP;
                    end
                end

                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                    bus.wb_sel     = (opcode_q == OP_LOAD) ? 2'b01 : 2'b00;
                    state_d        = S_FETCH;
                end

                S_TRAP: begin
                    if (bus.trap_ack) begin
                        state_d = S_FETCH;
                    end
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign bus.illegal   = illegal_q;
    assign bus.mem_fault = fault_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks ADD, LW with wait
// states, SW, BEQ taken/not-taken, JAL, JALR, an illegal opcode, FETCH and
// MEM timeouts (including the ready-at-the-limit case) and a mid-MEM reset.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic [1:0] mem_size;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_done;
        logic       illegal;
        logic       mem_fault;
    } outs_t;

    logic  clk;
    logic  rst;
    int    total;
    int    bad;
    outs_t obs;
    outs_t e;

    multicycle_control_unit_if ifc ();

    multicycle_control_unit #(
        .MEM_TIMEOUT (15),
        .TMO_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        obs = {ifc.state, ifc.pc_write, ifc.pc_src, ifc.ir_write, ifc.mem_req,
               ifc.mem_we, ifc.mem_size, ifc.alu_op, ifc.alu_src_a,
               ifc.alu_src_b, ifc.reg_write, ifc.wb_sel, ifc.instr_done,
               ifc.illegal, ifc.mem_fault};
    end

    function automatic outs_t fetch_exp(input logic rdy);
        outs_t f;
        f           = '0;
        f.mem_req   = 1'b1;
        f.mem_size  = 2'b10;
        f.alu_src_a = 1'b1;
        f.alu_src_b = 2'b10;
        if (rdy) begin
            f.ir_write = 1'b1;
            f.pc_write = 1'b1;
        end
        return f;
    endfunction

    function automatic outs_t st_only(input logic [2:0] s);
        outs_t f;
        f       = '0;
        f.state = s;
        return f;
    endfunction

    task automatic chk(input string tag, input outs_t exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are already set; check mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input outs_t exp);
        #1;
        chk(tag, exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ifc.opcode       = 7'b0000000;
        ifc.funct3       = 3'b000;
        ifc.mem_ready    = 1'b0;
        ifc.branch_taken = 1'b0;
        ifc.trap_ack     = 1'b0;

        @(posedge clk);
        #2;
        chk("reset_held", '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("release_fetch", fetch_exp(1'b0));

        // ADD, trap_ack asserted outside TRAP must be ignored
        ifc.opcode    = 7'b0110011;
        ifc.mem_ready = 1'b1;
        ifc.trap_ack  = 1'b1;
        cyc("add_fetch", fetch_exp(1'b1));
        cyc("add_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_op = 2'b10;
        cyc("add_exec", e);
        e = st_only(3'd4); e.reg_write = 1'b1; e.instr_done = 1'b1;
        cyc("add_wb", e);
        ifc.trap_ack = 1'b0;

        // LW, 3 wait states in MEM
        ifc.opcode = 7'b0000011;
        ifc.funct3 = 3'b010;
        cyc("lw_fetch", fetch_exp(1'b1));
        cyc("lw_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_src_b = 2'b01;
        cyc("lw_exec", e);
        ifc.mem_ready = 1'b0;
        e = st_only(3'd3); e.mem_req = 1'b1; e.mem_size = 2'b10;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", e);
        ifc.mem_ready = 1'b1;
        cyc("lw_mem_ready", e);
        e = st_only(3'd4); e.reg_write = 1'b1; e.instr_done = 1'b1; e.wb_sel = 2'b01;
        cyc("lw_wb", e);

        // SW
        ifc.opcode = 7'b0100011;
        cyc("sw_fetch", fetch_exp(1'b1));
        cyc("sw_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_src_b = 2'b01;
        cyc("sw_exec", e);
        e = st_only(3'd3); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_size = 2'b10;
        e.instr_done = 1'b1;
        cyc("sw_mem", e);

        // BEQ taken
        ifc.opcode       = 7'b1100011;
        ifc.funct3       = 3'b000;
        ifc.branch_taken = 1'b1;
        cyc("beq_t_fetch", fetch_exp(1'b1));
        cyc("beq_t_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = 2'b01;
        e.instr_done = 1'b1;
        cyc("beq_t_exec", e);

        // BEQ not taken
        ifc.branch_taken = 1'b0;
        cyc("beq_n_fetch", fetch_exp(1'b1));
        cyc("beq_n_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_op = 2'b01; e.pc_src = 2'b01; e.instr_done = 1'b1;
        cyc("beq_n_exec", e);

        // JAL
        ifc.opcode = 7'b1101111;
        cyc("jal_fetch", fetch_exp(1'b1));
        cyc("jal_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b01; e.pc_write = 1'b1;
        e.pc_src = 2'b01; e.reg_write = 1'b1; e.wb_sel = 2'b10; e.instr_done = 1'b1;
        cyc("jal_exec", e);

        // JALR
        ifc.opcode = 7'b1100111;
        cyc("jalr_fetch", fetch_exp(1'b1));
        cyc("jalr_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_src_b = 2'b01; e.pc_write = 1'b1;
        e.pc_src = 2'b10; e.reg_write = 1'b1; e.wb_sel = 2'b10; e.instr_done = 1'b1;
        cyc("jalr_exec", e);

        // Illegal opcode 0000000
        ifc.opcode = 7'b0000000;
        cyc("ill_fetch", fetch_exp(1'b1));
        cyc("ill_decode", st_only(3'd1));
        e = st_only(3'd5); e.illegal = 1'b1;
        cyc("ill_trap_hold0", e);
        cyc("ill_trap_hold1", e);
        ifc.trap_ack = 1'b1;
        cyc("ill_trap_ack", e);
        ifc.trap_ack  = 1'b0;
        ifc.mem_ready = 1'b0;

        // FETCH timeout: 16 waiting cycles then TRAP with mem_req dropped
        for (int i = 0; i < 16; i++) cyc("tmo_fetch_wait", fetch_exp(1'b0));
        e = st_only(3'd5); e.mem_fault = 1'b1;
        cyc("tmo_fetch_trap", e);
        ifc.trap_ack = 1'b1;
        cyc("tmo_fetch_ack", e);
        ifc.trap_ack = 1'b0;

        // Ready arriving exactly at the limit wins: no fault
        ifc.opcode = 7'b0010011;
        for (int i = 0; i < 15; i++) cyc("edge_fetch_wait", fetch_exp(1'b0));
        ifc.mem_ready = 1'b1;
        cyc("edge_fetch_ready", fetch_exp(1'b1));
        cyc("edge_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_op = 2'b10; e.alu_src_b = 2'b01;
        cyc("opimm_exec", e);
        e = st_only(3'd4); e.reg_write = 1'b1; e.instr_done = 1'b1;
        cyc("opimm_wb", e);

        // MEM timeout on a halfword load
        ifc.opcode = 7'b0000011;
        ifc.funct3 = 3'b001;
        cyc("lh_fetch", fetch_exp(1'b1));
        cyc("lh_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_src_b = 2'b01;
        cyc("lh_exec", e);
        ifc.mem_ready = 1'b0;
        e = st_only(3'd3); e.mem_req = 1'b1; e.mem_size = 2'b01;
        for (int i = 0; i < 16; i++) cyc("tmo_mem_wait", e);
        e = st_only(3'd5); e.mem_fault = 1'b1;
        cyc("tmo_mem_trap", e);
        ifc.trap_ack = 1'b1;
        cyc("tmo_mem_ack", e);
        ifc.trap_ack = 1'b0;

        // Async reset in the middle of a MEM wait
        ifc.mem_ready = 1'b1;
        ifc.funct3    = 3'b010;
        cyc("rst_lw_fetch", fetch_exp(1'b1));
        cyc("rst_lw_decode", st_only(3'd1));
        e = st_only(3'd2); e.alu_src_b = 2'b01;
        cyc("rst_lw_exec", e);
        ifc.mem_ready = 1'b0;
        e = st_only(3'd3); e.mem_req = 1'b1; e.mem_size = 2'b10;
        cyc("rst_lw_mem", e);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem", '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_release_fetch", fetch_exp(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
